// File: rtl/trace_readout.sv
// trace_readout
//   Drains the trace buffer and serializes its entries into a byte stream
//   for the host-side link. A start request snapshots the current entry
//   count N. When TRACE_READOUT_HDR_EN is defined, the stream begins with
//   a 2-byte little-endian count header. Each entry is then sent as
//   BITWIDTH/8 bytes, LSB first. The entry is dequeued from the trace
//   buffer as it is loaded. The stream length is always 2*HDR +
//   N*BITWIDTH/8 bytes. If the buffer runs dry mid-dump, the missing
//   entries are sent as zero padding.
//
//   Parameters:
//     BITWIDTH  trace entry width, multiple of 8
//     BITDEPTH  trace buffer holds 2**BITDEPTH entries, BITDEPTH <= 15
//
//   Configuration macro:
//     TRACE_READOUT_HDR_EN  when defined, the count header (HDR0/HDR1) is
//                           part of the stream
//
//   Ports:
//     clk, resetn   clock, synchronous active-low reset
//     start_i       begin a dump (only accepted in IDLE, not with abort_i)
//     abort_i       terminate a dump, back to IDLE without done_o
//     tb_rport_i    trace buffer head entry (combinational from its pointer)
//     tb_empty_i    trace buffer empty flag
//     tb_count_i    trace buffer entry count
//     tb_rdeq_o     dequeue strobe, one cycle per entry
//     tx_data_o     output byte
//     tx_valid_o    tx_data_o valid
//     tx_ready_i    consumer ready
//     busy_o        dump in progress
//     done_o        one-cycle pulse after the last byte was accepted
//     dbg_state     current FSM state encoding, for observation only
//
//   Handshake: a byte transfers on every cycle where tx_valid_o and
//   tx_ready_i are both high. Once tx_valid_o is raised, tx_valid_o and
//   tx_data_o hold unchanged until that transfer happens. Abort and reset
//   are the only exceptions: they drop the byte in flight.

module trace_readout #(
    parameter int BITWIDTH = 16,
    parameter int BITDEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [BITWIDTH-1:0] tb_rport_i,
    input  logic                tb_empty_i,
    input  logic [BITDEPTH:0]   tb_count_i,
    output logic                tb_rdeq_o,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [2:0]          dbg_state
);

    localparam int NBYTES = BITWIDTH / 8;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
`ifdef TRACE_READOUT_HDR_EN
        HDR0  = 3'd1,
        HDR1  = 3'd2,
`endif
        LOAD  = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                state, state_d;
    logic [BITDEPTH:0]     rem, rem_d;
    logic [IW-1:0]         idx, idx_d;
    logic [BITWIDTH-1:0]   shreg, shreg_d;
    logic [BITWIDTH-1:0]   load_val;
    logic [BITWIDTH-1:0]   shifted;
    logic [7:0]            tx_data_d;
    logic                  tx_valid_d;
    logic                  rdeq_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  accept;
`ifdef TRACE_READOUT_HDR_EN
    logic [BITDEPTH:0]     n_q, n_d;
`endif

    assign dbg_state = state;

    // Registered next-state and output logic.
    // tb_rdeq_o is a registered output, but it must be high during the LOAD
    // cycle itself. So it is decided on the transition into LOAD: it is set
    // when entries remain to be sent and the buffer is not empty. If the
    // buffer empties in that same cycle, LOAD sends padding instead of the
    // stale head entry.
    always_comb begin
        state_d    = state;
        rem_d      = rem;
        idx_d      = idx;
        shreg_d    = shreg;
        tx_data_d  = tx_data_o;
        tx_valid_d = tx_valid_o;
        rdeq_d     = 1'b0;
        busy_d     = busy_o;
        done_d     = 1'b0;
`ifdef TRACE_READOUT_HDR_EN
        n_d        = n_q;
`endif
        accept   = tx_valid_o & tx_ready_i;
        load_val = (tb_rdeq_o && !tb_empty_i) ? tb_rport_i : '0;
        shifted  = shreg >> 8;

        case (state)
            IDLE: begin
                if (start_i && !abort_i) begin
                    rem_d  = tb_count_i;
                    busy_d = 1'b1;
`ifdef TRACE_READOUT_HDR_EN
                    n_d        = tb_count_i;
                    state_d    = HDR0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'(16'(tb_count_i));
`else
                    state_d = LOAD;
                    rdeq_d  = (tb_count_i != '0) && !tb_empty_i;
`endif
                end
            end
`ifdef TRACE_READOUT_HDR_EN
            HDR0: begin
                if (accept) begin
                    state_d   = HDR1;
                    tx_data_d = 8'(16'(n_q) >> 8);
                end
            end
            HDR1: begin
                if (accept) begin
                    state_d    = LOAD;
                    tx_valid_d = 1'b0;
                    rdeq_d     = (rem != '0) && !tb_empty_i;
                end
            end
`endif
            LOAD: begin
                if (rem == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    shreg_d    = load_val;
                    tx_data_d  = load_val[7:0];
                    tx_valid_d = 1'b1;
                    rem_d      = rem - 1'b1;
                    idx_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        state_d    = LOAD;
                        tx_valid_d = 1'b0;
                        rdeq_d     = (rem != '0) && !tb_empty_i;
                    end else begin
                        shreg_d   = shifted;
                        tx_data_d = shifted[7:0];
                        idx_d     = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything else; any byte in flight is dropped.
        if (abort_i && state != IDLE) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            rdeq_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            rem        <= '0;
            idx        <= '0;
            shreg      <= '0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            tb_rdeq_o  <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
`ifdef TRACE_READOUT_HDR_EN
            n_q        <= '0;
`endif
        end else begin
            state      <= state_d;
            rem        <= rem_d;
            idx        <= idx_d;
            shreg      <= shreg_d;
            tx_data_o  <= tx_data_d;
            tx_valid_o <= tx_valid_d;
            tb_rdeq_o  <= rdeq_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
`ifdef TRACE_READOUT_HDR_EN
            n_q        <= n_d;
`endif
        end
    end

endmodule
